// File: rtl/load_align_pkg.sv
// Shared types for the load alignment path: access sizes, FSM states and
// the size-to-byte-count helper.
package load_align_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        WAIT0,
        ISSUE1,
        WAIT1,
        DONE
    } state_e;

    function automatic int bytes_of(input logic [1:0] size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/load_align_unit_lane_extract.sv
// Combinational lane extractor: picks the addressed bytes out of one or two
// bus beats and sign- or zero-extends them to the full bus width.
module lane_extract
    import load_align_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] beat0,
    input  logic [DATA_W-1:0] beat1,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] ext_data
);

    localparam int NB = DATA_W / 8;

    logic [2*DATA_W-1:0] merged;
    logic [DATA_W-1:0]   low;
    logic [DATA_W-1:0]   sign_mask;
    logic [DATA_W-1:0]   keep_mask;
    int                  nbytes;

    // sign_mask marks the top bit of the loaded field; keep_mask covers the field
    always_comb begin
        nbytes = bytes_of(size);
        if (nbytes > NB) nbytes = NB;
        merged    = {beat1, beat0} >> {off, 3'b000};
        low       = merged[DATA_W-1:0];
        sign_mask = {{(DATA_W-1){1'b0}}, 1'b1} << (8 * nbytes - 1);
        keep_mask = sign_mask | (sign_mask - DATA_W'(1));
        if (sign_ext && |(low & sign_mask)) ext_data = low | ~keep_mask;
        else                                ext_data = low & keep_mask;
    end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment stage: fetches one or two bus beats for a load and returns
// the extended result, optionally rejecting lane-crossing loads.
module load_align_unit
    import load_align_pkg::*;
#(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    state_e            state;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [OFF_W-1:0]  off_q;
    logic              cross_q;
    logic [DATA_W-1:0] beat0_q;
    logic [DATA_W-1:0] beat1_q;

    logic [1:0]        req_size_eff;
    logic [OFF_W-1:0]  req_off;
    logic              req_cross;
    logic [ADDR_W-1:0] req_base;

    logic [DATA_W-1:0] lane_beat0;
    logic [DATA_W-1:0] lane_beat1;
    logic [DATA_W-1:0] lane_data;

    // A dword on a 32-bit bus degrades to a word access
    always_comb begin
        req_size_eff = (DATA_W == 32 && req_size == SZ_DWORD) ? SZ_WORD : req_size;
        req_off      = req_addr[OFF_W-1:0];
        req_cross    = (int'(req_off) + bytes_of(req_size_eff)) > NB;
        req_base     = req_addr & ~ADDR_W'(NB - 1);
    end

    // Feed the arriving beat straight in so the result registers on entry to DONE
    assign lane_beat0 = (state == WAIT0) ? mem_rsp_data : beat0_q;
    assign lane_beat1 = (state == WAIT1) ? mem_rsp_data : beat1_q;

    lane_extract #(
        .DATA_W (DATA_W)
    ) u_lane_extract (
        .beat0    (lane_beat0),
        .beat1    (lane_beat1),
        .off      (off_q),
        .size     (size_q),
        .sign_ext (sign_q),
        .ext_data (lane_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            size_q        <= SZ_BYTE;
            sign_q        <= 1'b0;
            off_q         <= '0;
            cross_q       <= 1'b0;
            beat0_q       <= '0;
            beat1_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q    <= req_size_eff;
                        sign_q    <= req_signed;
                        off_q     <= req_off;
                        cross_q   <= req_cross;
                        req_ready <= 1'b0;
                        if (req_cross && !ALLOW_MISALIGNED) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state         <= ISSUE0;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= req_base;
                        end
                    end
                end
                ISSUE0: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT0;
                    end
                end
                WAIT0: begin
                    if (mem_rsp_valid) begin
                        beat0_q <= mem_rsp_data;
                        if (cross_q) begin
                            state         <= ISSUE1;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= mem_req_addr + ADDR_W'(NB);
                        end else begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= lane_data;
                        end
                    end
                end
                ISSUE1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT1;
                    end
                end
                WAIT1: begin
                    if (mem_rsp_valid) begin
                        beat1_q   <= mem_rsp_data;
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= lane_data;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Parametrised load-data alignment stage between the data-memory port and the writeback mux. It accepts one load request at a time: address, size and signedness. It fetches one or two bus beats from memory, extracts the addressed byte lanes, and sign- or zero-extends them to DATA_W. Unlike a fixed half-word selector, it handles byte, half, word (and dword when DATA_W=64) loads. Misaligned loads are either split into two beats or flagged as errors.

Parameters:
DATA_W, 32, bus/register width; legal values 32 or 64.
ADDR_W, 32, byte-address width.
ALLOW_MISALIGNED, 1, 1 = split lane-crossing loads into two beats; 0 = report error, no memory access.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  1  load request valid.
req_ready  output  1  unit idle, request accepted when req_valid&req_ready.
req_addr  input  ADDR_W  byte address.
req_size  input  2  0 byte, 1 half, 2 word, 3 dword (dword illegal when DATA_W=32: treated as word).
req_signed  input  1  1 = sign-extend, 0 = zero-extend.
mem_req_valid  output  1  memory read issue.
mem_req_ready  input  1  memory accepts issue.
mem_req_addr  output  ADDR_W  bus-aligned address (low log2(DATA_W/8) bits zero).
mem_rsp_valid  input  1  read data valid (one per accepted issue, in order).
mem_rsp_data  input  DATA_W  read data.
rsp_valid  output  1  result valid, held until rsp_ready.
rsp_ready  input  1  consumer accepts result.
rsp_data  output  DATA_W  extended load result.
rsp_err  output  1  misaligned load rejected (ALLOW_MISALIGNED=0 only).

Behaviour:
- Reset: state IDLE; req_ready=1; mem_req_valid=0, mem_req_addr=0; rsp_valid=0, rsp_data=0, rsp_err=0; captured beats cleared.
- Byte lanes are little-endian: lane k = data[8k+7:8k]. NB = DATA_W/8. off = addr mod NB. bytes = 1<<size.
- cross = (off + bytes > NB).
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE.
- IDLE:
  - req_ready=1 only here.
  - On accept, latch addr, size, signed, off and cross.
  - If cross and ALLOW_MISALIGNED=0 -> DONE with rsp_err=1, rsp_data=0.
  - Otherwise -> ISSUE0.
- ISSUE0: mem_req_valid=1, mem_req_addr=addr&~(NB-1). On mem_req_ready -> WAIT0.
- WAIT0: on mem_rsp_valid capture beat0. If cross -> ISSUE1, else -> DONE.
- ISSUE1: mem_req_addr = beat0 address + NB, wrapping modulo 2^ADDR_W. On mem_req_ready -> WAIT1.
- WAIT1: on mem_rsp_valid capture beat1 -> DONE.
- Result computation:
  - merged = {beat1, beat0} >> (8*off).
  - Take the low 8*bytes bits, then extend per signed to DATA_W.
  - The result is registered on entry to DONE.
- DONE:
  - rsp_valid=1; rsp_data and rsp_err stable until rsp_ready.
  - On rsp_ready -> IDLE.
  - req_ready=0 in DONE, so there is no same-cycle re-accept.
- Latency, counted from accept at cycle T with mem_req_ready=1 and mem_rsp_valid one cycle after issue:
  - aligned: rsp_valid at T+3.
  - split: rsp_valid at T+5.
  - error: rsp_valid at T+1.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored.
- mem_req_valid, once raised, stays high with stable address until mem_req_ready.
- rsp_ready held high in DONE gives single-cycle rsp_valid.
- rsp_ready while rsp_valid=0 has no effect.
- Reset mid-operation: immediate return to IDLE with reset values; the partial beat is discarded. The memory side is reset by the same rst_n.
- Exactly one outstanding load; no pipelining.

Decomposition:
- Package load_align_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - FSM state enum;
  - function bytes_of(size).
- One natural sub-module: lane_extract. It is purely combinational: inputs beat0, beat1, off, size, signed; output the extended value. It is reused by the store-side alignment unit later.

Test Plan:
- Reset mid-operation: rst_n low while in WAIT1 -> all outputs at reset values immediately; the next request behaves normally.
- DATA_W=32, addr 0x1001, byte, signed, mem word 0x1234_80FF -> one issue at 0x1000; rsp_data 0xFFFF_FF80, err 0, latency 3.
- DATA_W=32, addr 0x1002, half, unsigned, word 0x8765_4321 -> rsp_data 0x0000_8765.
- ALLOW_MISALIGNED=1, addr 0x1003, word, beats 0xAA00_0000 then 0x0000_00BB_CCDD (low 3 bytes 0xBB_CCDD) -> issues at 0x1000 then 0x1004; rsp_data 0xBBCC_DDAA; latency 5.
- ALLOW_MISALIGNED=0, addr 0x1003, half -> no mem_req_valid ever; rsp_valid at T+1 with err 1, data 0.
- Backpressure: mem_req_ready low for 4 cycles and rsp_ready low for 3 cycles -> mem_req_addr and rsp_data stable throughout; req_ready=0 until the rsp handshake; stray mem_rsp_valid in IDLE ignored.
